// File: rtl/mem_arbiter8.sv
// mem_arbiter8: shares one memory port between fetch (I) and data (D) requesters, D-priority with a fetch-starvation limit.
// Optional grant counters enabled by defining ARB_STATS_EN.
module mem_arbiter8 #(
  parameter int AW = 8,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_D_STREAK = 3
) (
  input  logic          clk,
  input  logic          master_reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [7:0]    i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [7:0]    d_wdata,
  output logic          d_ack,
  output logic [7:0]    d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   i_grant_cnt,
  output logic [15:0]   d_grant_cnt
`endif
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int LW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic grant, d_win;
  assign grant = (state_q == IDLE) & (i_req | d_req);
  // D loses only when fetch has already waited through MAX_D_STREAK D grants
  assign d_win = d_req & ~(i_req & (streak_q == SW'(MAX_D_STREAK)));
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    streak_d = streak_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = ACCESS;
        owner_d = d_win;
        we_d = d_win & d_we;
        addr_d = d_win ? d_addr : i_addr;
        wdata_d = d_wdata;
        streak_d = (d_win & i_req) ? streak_q + 1'b1 : '0;
      end
      ACCESS: begin
        state_d = we_q ? RESP : WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LW'(MEM_LATENCY - 1)) begin
          state_d = RESP;
          d_rdata_d = owner_q ? mem_rdata : d_rdata_q;
          i_rdata_d = owner_q ? i_rdata_q : mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (master_reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      streak_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      streak_q <= streak_d;
      cnt_q <= cnt_d;
    end
  end
  assign mem_en = state_q == ACCESS;
  assign mem_we = mem_en & we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign busy = state_q != IDLE;
  assign i_ack = (state_q == RESP) & ~owner_q;
  assign d_ack = (state_q == RESP) & owner_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
`ifdef ARB_STATS_EN
  logic [15:0] i_cnt_q, d_cnt_q;
  always_ff @(posedge clk) begin
    if (master_reset) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      if (grant & ~d_win & (i_cnt_q != 16'hFFFF)) i_cnt_q <= i_cnt_q + 1'b1;
      if (grant & d_win & (d_cnt_q != 16'hFFFF)) d_cnt_q <= d_cnt_q + 1'b1;
    end
  end
  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;
`endif
endmodule

// File: tb/tb_mem_arbiter8.sv
// tb_mem_arbiter8: directed table, corner sequences and random traffic against a transaction-level model of mem_arbiter8.
module tb_mem_arbiter8;
  localparam int AW = 8, L = 2, MS = 3;
  logic clk = 0, master_reset = 1;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [AW-1:0] i_addr = 0, d_addr = 0;
  logic [7:0] d_wdata = 0;
  logic i_ack, d_ack, mem_en, mem_we, busy;
  logic [7:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
`ifdef ARB_STATS_EN
  logic [15:0] i_grant_cnt, d_grant_cnt;
`endif

  mem_arbiter8 #(.AW(AW), .MEM_LATENCY(L), .MAX_D_STREAK(MS)) dut (
    .clk(clk), .master_reset(master_reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
`ifdef ARB_STATS_EN
    , .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [7:0] init_val(input int k);
    return k == 16 ? 8'hA5 : k == 5 ? 8'h11 : k == 6 ? 8'h22 : 8'(k * 37 + 11);
  endfunction

  // Memory macro model: data appears on mem_rdata L cycles after the strobe, junk otherwise
  logic [7:0] mem [256];
  logic [7:0] pipe [L];
  bit mem_ready = 0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_val(k);
      mem_ready <= 1;
    end else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 8'($urandom);
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[L-1];

  // Transaction-level reference: one grant at a time, timing from the grant cycle
  bit model_on = 0, ref_init = 0, own_d = 0, we_m = 0;
  int free_at = -1, acc_cyc = -1, ack_cyc = -1, streak = 0;
  logic [7:0] a_m = 0, wd_m = 0, rd_m = 0, exp_ir = 0, exp_dr = 0, exp_ma = 0;
  logic [7:0] ref_mem [256];
  bit grants[$];
  always @(negedge clk) begin
    if (!ref_init) begin
      for (int k = 0; k < 256; k++) ref_mem[k] = init_val(k);
      ref_init = 1;
    end
    if (model_on) begin
      if (cyc == ack_cyc && !we_m) begin
        if (own_d) exp_dr = rd_m; else exp_ir = rd_m;
      end
      chk("busy", busy, cyc != free_at);
      chk("i_ack", i_ack, cyc == ack_cyc && !own_d);
      chk("d_ack", d_ack, cyc == ack_cyc && own_d);
      chk("mem_en", mem_en, cyc == acc_cyc);
      chk("mem_we", mem_we, cyc == acc_cyc && we_m);
      chk("mem_addr", mem_addr, exp_ma);
      if (cyc == acc_cyc && we_m) chk("mem_wdata", mem_wdata, wd_m);
      chk("i_rdata", i_rdata, exp_ir);
      chk("d_rdata", d_rdata, exp_dr);
    end
    if (master_reset) begin
      model_on = 1; free_at = cyc + 1; acc_cyc = -1; ack_cyc = -1; streak = 0;
      exp_ir = 0; exp_dr = 0; exp_ma = 0;
    end else if (model_on && cyc == free_at) begin
      if (i_req || d_req) begin
        own_d = d_req && !(i_req && streak == MS);
        streak = (own_d && i_req) ? (streak < MS ? streak + 1 : MS) : 0;
        we_m = own_d && d_we;
        a_m = own_d ? d_addr : i_addr;
        wd_m = d_wdata;
        rd_m = ref_mem[a_m];
        if (we_m) ref_mem[a_m] = wd_m;
        acc_cyc = cyc + 1;
        ack_cyc = cyc + 2 + (we_m ? 0 : L);
        free_at = ack_cyc + 1;
        exp_ma = a_m;
        grants.push_back(own_d);
      end else free_at = cyc + 1;
    end
    cyc++;
  end

  typedef struct {bit is_d; bit we; logic [7:0] a; logic [7:0] wd; logic [7:0] rd; int lat;} vec_t;
  vec_t vecs [6];

  task automatic wait_ack(input bit is_d, output bit got);
    int t = 0;
    got = 0;
    while (!got && t < 40) begin
      @(negedge clk); t++;
      got = is_d ? d_ack : i_ack;
    end
  endtask

  task automatic txn(input vec_t v);
    int t = 0;
    bit got = 0;
    @(posedge clk); #1;
    if (v.is_d) begin d_req = 1; d_we = v.we; d_addr = v.a; d_wdata = v.wd; end
    else begin i_req = 1; i_addr = v.a; end
    while (!got && t < 40) begin
      @(negedge clk); t++;
      got = v.is_d ? d_ack : i_ack;
      if (t == 2) begin
        #1; d_addr = ~v.a; d_wdata = ~v.wd; d_we = ~v.we; i_addr = ~v.a;
      end
    end
    chk("ack_seen", got, 1);
    chk("ack_latency", t - 1, v.lat);
    chk("port_rdata", v.is_d ? d_rdata : i_rdata, v.rd);
    @(posedge clk); #1;
    d_req = 0; i_req = 0;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    master_reset = 1; i_req = 0; d_req = 0;
    @(posedge clk); #1;
    master_reset = 0;
  endtask

  initial begin
    bit got, ia_prev, da_prev;
    int n0;
    vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 2 + L};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'h00, 2};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 2 + L};
    vecs[3] = '{1'b1, 1'b1, 8'h20, 8'h99, 8'h3C, 2};
    vecs[4] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h99, 2 + L};
    vecs[5] = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h11, 2 + L};
    repeat (3) @(posedge clk);
    #1 master_reset = 0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_rdata", {i_rdata, d_rdata}, 0);
`ifdef ARB_STATS_EN
    chk("stats_reset_i", i_grant_cnt, 0);
    repeat (5) txn('{1'b0, 1'b0, 8'h40, 8'h00, init_val(64), 2 + L});
    repeat (7) txn('{1'b1, 1'b1, 8'h41, 8'h5A, 8'h00, 2});
    chk("stats_i", i_grant_cnt, 5);
    chk("stats_d", d_grant_cnt, 7);
    do_reset;
    chk("stats_clr_i", i_grant_cnt, 0);
    chk("stats_clr_d", d_grant_cnt, 0);
`endif
    do_reset;
    for (int k = 0; k < 6; k++) txn(vecs[k]);

    // simultaneous requests: D first, I in the following IDLE cycle
    n0 = grants.size();
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 8'h05; i_req = 1; i_addr = 8'h06;
    wait_ack(1, got);
    chk("both_d_ack", got, 1);
    chk("both_d_rdata", d_rdata, 8'h11);
    chk("both_i_pending", i_ack, 0);
    @(posedge clk); #1; d_req = 0;
    wait_ack(0, got);
    chk("both_i_ack", got, 1);
    chk("both_i_rdata", i_rdata, 8'h22);
    @(posedge clk); #1; i_req = 0;
    chk("both_order_d", grants.size() > n0 + 1 ? grants[n0] : 0, 1);
    chk("both_order_i", grants.size() > n0 + 1 ? grants[n0+1] : 1, 0);

    // streak limiter with both requesters continuously asking
    do_reset;
    grants.delete();
    d_req = 1; d_we = 1; d_addr = 8'h30; d_wdata = 8'h77; i_req = 1; i_addr = 8'h31;
    repeat (40) @(posedge clk);
    #1; d_req = 0; i_req = 0;
    repeat (10) @(posedge clk);
    chk("streak_count", grants.size() >= 8, 1);
    for (int k = 0; k < 8; k++) if (grants.size() > k) chk("streak_grant", grants[k], (k % 4) != 3);

    // reset during WAIT of a D read
    do_reset;
    d_req = 1; d_we = 0; d_addr = 8'h05;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait_busy", busy, 1);
    master_reset = 1; d_req = 0;
    @(posedge clk); #1;
    master_reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_d_ack", d_ack, 0);
    chk("abort_d_rdata", d_rdata, 0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_ack", d_ack, 0);
      chk("abort_no_strobe", mem_en, 0);
    end
    txn(vecs[5]);

    // random traffic with occasional resets
    ia_prev = 0; da_prev = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      master_reset = $urandom_range(0, 399) == 0;
      if (master_reset) begin
        i_req = 0; d_req = 0;
      end else begin
        if (!i_req) i_req = $urandom_range(0, 2) == 0;
        else if (ia_prev) i_req = $urandom_range(0, 1) == 1;
        if (!d_req) d_req = $urandom_range(0, 1) == 0;
        else if (da_prev) d_req = $urandom_range(0, 1) == 1;
      end
      i_addr = 8'($urandom); d_addr = 8'($urandom);
      d_we = 1'($urandom); d_wdata = 8'($urandom);
      ia_prev = i_ack; da_prev = d_ack;
    end
    @(posedge clk); #1;
    master_reset = 0; i_req = 0; d_req = 0;
    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
